// File: rtl/wdt_pkg.sv
// Shared types and default constants for the watchdog timer.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WARN    = 2'd2,
    EXPIRED = 2'd3
  } wdt_state_t;

  localparam int WDT_CNT_W           = 16;
  localparam int WDT_TIMEOUT_DEFAULT = 500;
  localparam int WDT_WARN_THRESH     = 50;
  localparam int WDT_PRESCALE        = 1;
  localparam int WDT_EXP_CNT_W       = 8;

  // True in the states where the countdown is live.
  function automatic logic is_counting(wdt_state_t s);
    return (s == RUN) || (s == WARN);
  endfunction

endpackage

// File: rtl/wdt_if.sv
// Control and status bundle between the watchdog and whoever services it.
interface wdt_if
  import wdt_pkg::*;
#(
  parameter int CNT_W     = WDT_CNT_W,
  parameter int EXP_CNT_W = WDT_EXP_CNT_W
);

  logic                 en;
  logic                 kick;
  logic                 clear;
  logic                 timeout_load;
  logic [CNT_W-1:0]     timeout_val;
  logic [CNT_W-1:0]     count;
  wdt_state_t           state;
  logic                 warn;
  logic                 expired;
  logic                 expire_pulse;
  logic [EXP_CNT_W-1:0] expire_cnt;

  // Servicing side: drives controls, observes status.
  modport master (
    output en, kick, clear, timeout_load, timeout_val,
    input  count, state, warn, expired, expire_pulse, expire_cnt
  );

  // Watchdog side.
  modport slave (
    input  en, kick, clear, timeout_load, timeout_val,
    output count, state, warn, expired, expire_pulse, expire_cnt
  );

endinterface

// File: rtl/wdt_prescaler.sv
// Divides clk into countdown ticks; one tick every PRESCALE cycles while running.
module wdt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic resetf,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int              PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // Phase counter: held at zero when idle or restarted, wraps on each tick.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      cnt <= '0;
    end else if (!run || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/wdt_core.sv
// Watchdog timer: programmable countdown, warn window, sticky expiry and expiry tally.
module wdt_core
  import wdt_pkg::*;
#(
  parameter int CNT_W           = WDT_CNT_W,
  parameter int TIMEOUT_DEFAULT = WDT_TIMEOUT_DEFAULT,
  parameter int WARN_THRESH     = WDT_WARN_THRESH,
  parameter int PRESCALE        = WDT_PRESCALE,
  parameter int EXP_CNT_W       = WDT_EXP_CNT_W
) (
  input logic   clk,
  input logic   resetf,
  wdt_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_INIT = CNT_W'(TIMEOUT_DEFAULT);
  localparam logic [CNT_W-1:0] WARN_TH      = CNT_W'(WARN_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [CNT_W-1:0]     timeout_reg;
  logic [CNT_W-1:0]     count_q;
  wdt_state_t           state_q;
  logic                 warn_q;
  logic                 expired_q;
  logic                 pulse_q;
  logic [EXP_CNT_W-1:0] exp_cnt_q;

  logic                 tick;
  logic [CNT_W-1:0]     count_dec;
  wdt_state_t           reload_state;
  wdt_state_t           dec_state;

  // A reload or decrement lands in WARN when the resulting count is inside the window.
  assign count_dec    = count_q - CNT_ONE;
  assign reload_state = (timeout_reg <= WARN_TH) ? WARN : RUN;
  assign dec_state    = (count_dec   <= WARN_TH) ? WARN : RUN;

  // Kick and disable restart the tick phase so a fresh period always starts whole.
  wdt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .resetf (resetf),
    .run    (is_counting(state_q)),
    .clr    (bus.kick | ~bus.en),
    .tick   (tick)
  );

  // Timeout register; zero would expire without ever counting, so it becomes one.
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      timeout_reg <= TIMEOUT_INIT;
    end else if (bus.timeout_load) begin
      timeout_reg <= (bus.timeout_val == '0) ? CNT_ONE : bus.timeout_val;
    end
  end

  // Watchdog FSM with countdown, registered flags and expiry tally.
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      state_q   <= IDLE;
      count_q   <= TIMEOUT_INIT;
      warn_q    <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      exp_cnt_q <= '0;
    end else begin
      // NOTE: the pulse defaults low every cycle so it can never stretch past one clock.
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= timeout_reg;
          if (bus.en) begin
            state_q <= reload_state;
            warn_q  <= (reload_state == WARN);
          end
        end
        RUN, WARN: begin
          if (!bus.en) begin
            state_q <= IDLE;
            warn_q  <= 1'b0;
            count_q <= timeout_reg;
          end else if (bus.kick) begin
            state_q <= reload_state;
            warn_q  <= (reload_state == WARN);
            count_q <= timeout_reg;
          end else if (tick) begin
            if (count_q <= CNT_ONE) begin
              state_q   <= EXPIRED;
              warn_q    <= 1'b0;
              expired_q <= 1'b1;
              pulse_q   <= 1'b1;
              count_q   <= '0;
              if (exp_cnt_q != '1) begin
                exp_cnt_q <= exp_cnt_q + EXP_CNT_W'(1);
              end
            end else begin
              state_q <= dec_state;
              warn_q  <= (dec_state == WARN);
              count_q <= count_dec;
            end
          end
        end
        EXPIRED: begin
          if (bus.clear) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
            count_q   <= timeout_reg;
          end
        end
        default: begin
          state_q <= IDLE;
          warn_q  <= 1'b0;
          count_q <= timeout_reg;
        end
      endcase
    end
  end

  assign bus.count        = count_q;
  assign bus.state        = state_q;
  assign bus.warn         = warn_q;
  assign bus.expired      = expired_q;
  assign bus.expire_pulse = pulse_q;
  assign bus.expire_cnt   = exp_cnt_q;

endmodule

// File: tb/tb_wdt_core.sv
// Directed testbench for wdt_core (TIMEOUT_DEFAULT=500, WARN_THRESH=50, PRESCALE=1).
module tb_wdt_core;
  import wdt_pkg::*;

  logic clk;
  logic resetf;
  int   checks   = 0;
  int   failures = 0;

  wdt_if #(.CNT_W(16), .EXP_CNT_W(8)) bus ();

  wdt_core #(
    .CNT_W           (16),
    .TIMEOUT_DEFAULT (500),
    .WARN_THRESH     (50),
    .PRESCALE        (1),
    .EXP_CNT_W       (8)
  ) dut (
    .clk    (clk),
    .resetf (resetf),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // Advance one edge and land 1ns after it, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetf = 1'b0;
    bus.en = 1'b0; bus.kick = 1'b0; bus.clear = 1'b0;
    bus.timeout_load = 1'b0; bus.timeout_val = '0;
    repeat (3) @(posedge clk);
    #1 resetf = 1'b1;
    step();
    checks++; if (bus.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
    checks++; if (bus.count !== 16'd500) begin failures++; $display("FAIL reset_count: got %0d expected 500", bus.count); end
    checks++; if (bus.warn !== 1'b0 || bus.expired !== 1'b0 || bus.expire_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got warn=%b expired=%b pulse=%b expected 0 0 0", bus.warn, bus.expired, bus.expire_pulse); end
    checks++; if (bus.expire_cnt !== 8'd0) begin failures++; $display("FAIL reset_expire_cnt: got %0d expected 0", bus.expire_cnt); end
  endtask

  task automatic test_expiry();
    int  warn_k = -1;
    int  warn_count = -1;
    int  pulse_k = -1;
    bit  count_ok = 1'b1;
    bus.en = 1'b1;
    step();
    checks++; if (bus.state !== RUN || bus.count !== 16'd500) begin
      failures++; $display("FAIL run_entry: got state=%0d count=%0d expected state=1 count=500", bus.state, bus.count); end
    for (int i = 1; i <= 600 && pulse_k < 0; i++) begin
      step();
      if (bus.count !== 16'(500 - i)) count_ok = 1'b0;
      if (bus.warn === 1'b1 && warn_k < 0) begin warn_k = i; warn_count = int'(bus.count); end
      if (bus.expire_pulse === 1'b1) pulse_k = i;
    end
    checks++; if (!count_ok) begin failures++; $display("FAIL countdown_track: got off-sequence count expected 500-i each cycle"); end
    checks++; if (warn_k != 450 || warn_count != 50) begin
      failures++; $display("FAIL warn_onset: got cycle=%0d count=%0d expected cycle=450 count=50", warn_k, warn_count); end
    checks++; if (pulse_k != 500) begin failures++; $display("FAIL expire_time: got cycle=%0d expected 500", pulse_k); end
    checks++; if (bus.state !== EXPIRED || bus.expired !== 1'b1 || bus.count !== 16'd0 || bus.warn !== 1'b0) begin
      failures++; $display("FAIL expired_state: got state=%0d expired=%b count=%0d warn=%b expected 3 1 0 0", bus.state, bus.expired, bus.count, bus.warn); end
    checks++; if (bus.expire_cnt !== 8'd1) begin failures++; $display("FAIL expire_cnt_first: got %0d expected 1", bus.expire_cnt); end
    step();
    checks++; if (bus.expire_pulse !== 1'b0 || bus.expired !== 1'b1) begin
      failures++; $display("FAIL pulse_width: got pulse=%b expired=%b expected 0 1", bus.expire_pulse, bus.expired); end
    bus.clear = 1'b1; bus.en = 1'b0;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.state !== IDLE || bus.count !== 16'd500 || bus.expired !== 1'b0) begin
      failures++; $display("FAIL clear_to_idle: got state=%0d count=%0d expired=%b expected 0 500 0", bus.state, bus.count, bus.expired); end
  endtask

  task automatic test_kick_periodic();
    bit saw_warn = 1'b0;
    bit saw_exp = 1'b0;
    int min_count = 65535;
    bus.en = 1'b1;
    step();
    for (int i = 0; i < 5000; i++) begin
      bus.kick = ((i % 400) == 399);
      step();
      if (bus.warn === 1'b1) saw_warn = 1'b1;
      if (bus.expired === 1'b1 || bus.expire_pulse === 1'b1) saw_exp = 1'b1;
      if (int'(bus.count) < min_count) min_count = int'(bus.count);
    end
    bus.kick = 1'b0;
    checks++; if (saw_warn) begin failures++; $display("FAIL kick_no_warn: got warn=1 expected never"); end
    checks++; if (saw_exp) begin failures++; $display("FAIL kick_no_expire: got expiry expected none"); end
    checks++; if (min_count != 101) begin failures++; $display("FAIL kick_min_count: got %0d expected 101", min_count); end
    bus.en = 1'b0;
    step();
    checks++; if (bus.state !== IDLE || bus.count !== 16'd500) begin
      failures++; $display("FAIL disable_idle: got state=%0d count=%0d expected 0 500", bus.state, bus.count); end
  endtask

  task automatic test_kick_at_final();
    bit saw_pulse = 1'b0;
    bus.en = 1'b1;
    step();
    repeat (499) begin step(); if (bus.expire_pulse === 1'b1) saw_pulse = 1'b1; end
    checks++; if (bus.count !== 16'd1 || bus.state !== WARN) begin
      failures++; $display("FAIL last_tick_setup: got count=%0d state=%0d expected 1 2", bus.count, bus.state); end
    bus.kick = 1'b1;
    step();
    bus.kick = 1'b0;
    checks++; if (bus.count !== 16'd500 || bus.state !== RUN || bus.warn !== 1'b0) begin
      failures++; $display("FAIL kick_beats_expiry: got count=%0d state=%0d warn=%b expected 500 1 0", bus.count, bus.state, bus.warn); end
    repeat (3) begin step(); if (bus.expire_pulse === 1'b1 || bus.expired === 1'b1) saw_pulse = 1'b1; end
    checks++; if (saw_pulse) begin failures++; $display("FAIL kick_final_pulse: got expiry expected none"); end
    bus.en = 1'b0;
    step();
  endtask

  task automatic test_timeout_load();
    bus.en = 1'b1;
    step();
    repeat (100) step();
    bus.timeout_load = 1'b1; bus.timeout_val = 16'd10;
    step();
    bus.timeout_load = 1'b0;
    checks++; if (bus.count !== 16'd399 || bus.state !== RUN) begin
      failures++; $display("FAIL load_no_effect: got count=%0d state=%0d expected 399 1", bus.count, bus.state); end
    repeat (5) step();
    bus.kick = 1'b1;
    step();
    checks++; if (bus.count !== 16'd10 || bus.state !== WARN || bus.warn !== 1'b1) begin
      failures++; $display("FAIL load_kick_warn: got count=%0d state=%0d warn=%b expected 10 2 1", bus.count, bus.state, bus.warn); end
    bus.timeout_load = 1'b1; bus.timeout_val = 16'd0;
    step();
    bus.timeout_load = 1'b0;
    checks++; if (bus.count !== 16'd10) begin failures++; $display("FAIL load_kick_old: got %0d expected 10", bus.count); end
    step();
    bus.kick = 1'b0;
    checks++; if (bus.count !== 16'd1 || bus.state !== WARN) begin
      failures++; $display("FAIL zero_clamp: got count=%0d state=%0d expected 1 2", bus.count, bus.state); end
    step();
    checks++; if (bus.state !== EXPIRED || bus.expire_pulse !== 1'b1 || bus.expire_cnt !== 8'd2) begin
      failures++; $display("FAIL short_expiry: got state=%0d pulse=%b cnt=%0d expected 3 1 2", bus.state, bus.expire_pulse, bus.expire_cnt); end
    bus.clear = 1'b1; bus.en = 1'b0;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.state !== IDLE || bus.count !== 16'd1) begin
      failures++; $display("FAIL clear_reload_one: got state=%0d count=%0d expected 0 1", bus.state, bus.count); end
  endtask

  task automatic test_expired_hold();
    int  pulses = 0;
    bit  hold_ok = 1'b1;
    bus.en = 1'b1;
    step();
    checks++; if (bus.state !== WARN || bus.count !== 16'd1 || bus.warn !== 1'b1) begin
      failures++; $display("FAIL idle_to_warn: got state=%0d count=%0d warn=%b expected 2 1 1", bus.state, bus.count, bus.warn); end
    step();
    for (int i = 0; i < 6; i++) begin
      bus.kick = i[0];
      bus.en   = i[1];
      step();
      if (bus.state !== EXPIRED || bus.count !== 16'd0 || bus.expired !== 1'b1 ||
          bus.expire_pulse !== 1'b0 || bus.expire_cnt !== 8'd3) hold_ok = 1'b0;
    end
    bus.kick = 1'b0; bus.en = 1'b1;
    checks++; if (!hold_ok) begin failures++; $display("FAIL expired_hold: got change under kick/en expected frozen EXPIRED"); end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.state !== IDLE || bus.count !== 16'd1 || bus.expired !== 1'b0) begin
      failures++; $display("FAIL hold_clear: got state=%0d count=%0d expired=%b expected 0 1 0", bus.state, bus.count, bus.expired); end
    step();
    for (int n = 0; n < 260; n++) begin
      step();
      if (bus.expire_pulse === 1'b1) pulses++;
      if (n == 251) begin
        checks++; if (bus.expire_cnt !== 8'd255) begin failures++; $display("FAIL expire_cnt_reach: got %0d expected 255", bus.expire_cnt); end
      end
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      step();
    end
    checks++; if (pulses != 260) begin failures++; $display("FAIL sat_pulses: got %0d expected 260", pulses); end
    checks++; if (bus.expire_cnt !== 8'd255) begin failures++; $display("FAIL expire_cnt_sat: got %0d expected 255", bus.expire_cnt); end
    bus.en = 1'b0; bus.timeout_load = 1'b1; bus.timeout_val = 16'd500;
    step();
    bus.timeout_load = 1'b0;
    step();
    checks++; if (bus.state !== IDLE || bus.count !== 16'd500) begin
      failures++; $display("FAIL idle_follow: got state=%0d count=%0d expected 0 500", bus.state, bus.count); end
  endtask

  task automatic test_reset_mid_warn();
    bit saw_pulse = 1'b0;
    bus.en = 1'b1;
    step();
    repeat (460) step();
    checks++; if (bus.state !== WARN || bus.count !== 16'd40) begin
      failures++; $display("FAIL pre_reset_warn: got state=%0d count=%0d expected 2 40", bus.state, bus.count); end
    #2 resetf = 1'b0;
    #1;
    checks++; if (bus.state !== IDLE || bus.warn !== 1'b0 || bus.count !== 16'd500 || bus.expire_pulse !== 1'b0) begin
      failures++; $display("FAIL async_reset: got state=%0d warn=%b count=%0d pulse=%b expected 0 0 500 0", bus.state, bus.warn, bus.count, bus.expire_pulse); end
    checks++; if (bus.expire_cnt !== 8'd0) begin failures++; $display("FAIL async_reset_cnt: got %0d expected 0", bus.expire_cnt); end
    bus.en = 1'b0;
    repeat (2) begin step(); if (bus.expire_pulse === 1'b1) saw_pulse = 1'b1; end
    resetf = 1'b1;
    step();
    if (bus.expire_pulse === 1'b1) saw_pulse = 1'b1;
    checks++; if (saw_pulse || bus.state !== IDLE || bus.count !== 16'd500) begin
      failures++; $display("FAIL post_reset: got pulse_seen=%b state=%0d count=%0d expected 0 0 500", saw_pulse, bus.state, bus.count); end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_kick_periodic();
    test_kick_at_final();
    test_timeout_load();
    test_expired_hold();
    test_reset_mid_warn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
